axi_lite_slave_mem: RTL and testbench
=====================================

Name: axi_lite_slave_mem

Overview:
Synthesisable AXI4-Lite slave memory, parametrised in address/data width, depth, base address and read latency. It replaces the simulation-only slave memory agents behind the instruction and data ports of the verifier, so the same program image can run in simulation and on hardware. A backdoor write port preloads the program image while the core is held in reset.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, data width; 32 or 64 only
DEPTH_WORDS, 1024, number of DATA_WIDTH words; power of two
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
RD_LATENCY, 1, cycles from AR handshake to RVALID; legal range 1..8

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_awaddr  in  ADDR_WIDTH  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_WIDTH  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DATA_WIDTH  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
bd_we  in  1  backdoor write enable
bd_addr  in  ADDR_WIDTH  backdoor byte address
bd_wdata  in  DATA_WIDTH  backdoor data
bd_wstrb  in  DATA_WIDTH/8  backdoor strobes
wr_count  out  32  completed AXI writes (B handshakes)
rd_count  out  32  completed AXI reads (R handshakes)

Behaviour:
- Clock and reset: one clock domain, clk; reset rst is synchronous and active-high.
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_count=0, rd_count=0. Memory contents are not cleared by reset.
- Reset mid-transaction: any in-flight transaction is abandoned with no memory commit and no response.
- Word index: ((addr - BASE_ADDR) >> log2(DATA_WIDTH/8)). Address bits below the word size are ignored.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP.
  - AW and W are accepted independently. Each ready drops once its beat has been captured.
  - Once both beats are held, go to W_COMMIT. The memory write happens in that cycle, per byte by wstrb.
  - The next cycle enters W_RESP with bvalid=1 and bresp=OKAY (2'b00).
  - bvalid holds until bready. On the bvalid&bready cycle: wr_count increments; awready and wready rise the next cycle; state returns to W_IDLE.
  - Only one write is outstanding at a time.
- Backdoor priority: when bd_we=1 in a W_COMMIT cycle, the backdoor write commits and the AXI commit is deferred by one cycle; bvalid is delayed by the same amount. Backdoor writes are accepted in any state and take effect in one cycle.
- Read FSM states: R_IDLE, R_WAIT, R_VALID.
  - arready=1 only in R_IDLE.
  - AR handshake at cycle T gives rvalid=1 at cycle T+RD_LATENCY, rresp=OKAY.
  - rdata reflects all writes committed strictly before cycle T.
  - rvalid and rdata hold stable until rready. On the rvalid&rready cycle: rd_count increments; state returns to R_IDLE; arready is 1 the next cycle.
- Read and write channels are independent. Same-word collision follows the before-T rule above.
- wr_count and rd_count wrap from 2^32-1 to 0.

Optional Feature:
Macro AXI_MEM_RANGE_CHECK_EN.
- Defined: an address below BASE_ADDR or at/above BASE_ADDR + DEPTH_WORDS*DATA_WIDTH/8 is out of range.
  - Out-of-range write: memory is not modified; bresp=DECERR (2'b11).
  - Out-of-range read: rdata=0, rresp=DECERR.
  - Out-of-range backdoor writes are dropped.
  - Handshake timing is unchanged.
- Undefined: word index wraps modulo DEPTH_WORDS and responses are always OKAY.

Test Plan:
- Preload: with rst=1, backdoor-write 32'h10000113 to addr 0x0 and 32'hF81FF06F to 0x80. Release reset, read 0x80 with RD_LATENCY=3 -> rvalid exactly 3 cycles after the AR handshake, rdata=32'hF81FF06F, rresp=0, rd_count=1.
- Partial strobe: write 32'hAABBCCDD with wstrb=4'b0101 over 32'h11223344 at 0x10 -> read returns 32'h11BB33DD; bresp=0; wr_count=1.
- Channel ordering: W presented 4 cycles before AW -> wready falls after the W beat; bvalid rises 2 cycles after the AW handshake. Hold bready=0 for 5 cycles -> bvalid stays 1 and awready stays 0 throughout.
- Collision: bd_we=1 to 0x20 in the W_COMMIT cycle of an AXI write to 0x24 -> both words are written; bvalid is 1 cycle late. rready held low 3 cycles on a read of 0x24 -> rdata stable throughout.
- Range check (AXI_MEM_RANGE_CHECK_EN, DEPTH_WORDS=1024): write to 0x1000 -> bresp=2'b11 and word 0 unchanged; read 0x1000 -> rdata=0, rresp=2'b11. Without the macro, a read of 0x1000 returns word 0.
- Reset mid-read: assert rst during R_WAIT -> rvalid=0 and arready=1 after reset; rd_count=0; preloaded memory is intact.

Source files
------------

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave memory with a backdoor preload port and configurable read latency.
// Define AXI_MEM_RANGE_CHECK_EN to answer out-of-range accesses with DECERR instead of wrapping.
module axi_lite_slave_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    RD_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    input  logic                    bd_we,
    input  logic [ADDR_WIDTH-1:0]   bd_addr,
    input  logic [DATA_WIDTH-1:0]   bd_wdata,
    input  logic [DATA_WIDTH/8-1:0] bd_wstrb,
    output logic [31:0]             wr_count,
    output logic [31:0]             rd_count
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH_WORDS * STRB_WIDTH);
    localparam logic [3:0] LAST_WAIT = 4'(RD_LATENCY - 1);
`ifdef AXI_MEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} rd_state_t;

    // Without range checking the truncation makes the index wrap modulo DEPTH_WORDS.
    function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_WIDTH'((addr - BASE_ADDR) >> ADDR_LSB);
    endfunction

    function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] off;
        off = {1'b0, addr - BASE_ADDR};
        return RANGE_EN && ((addr < BASE_ADDR) || (off >= SPAN));
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

    wr_state_t             wr_state_r, wr_next_s;
    rd_state_t             rd_state_r, rd_next_s;
    logic                  awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic                  awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
    logic [1:0]            bresp_r, bresp_s, rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r, rd_buf_r, rd_word_s;
    logic                  rd_oor_r, rd_oor_s;
    logic [IDX_WIDTH-1:0]  aw_idx_r;
    logic                  aw_oor_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_WIDTH-1:0] wstrb_r;
    logic [3:0]            lat_cnt_r;
    logic [31:0]           wr_count_r, rd_count_r;
    logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

    assign aw_hs_s = s_awvalid && awready_r;
    assign w_hs_s  = s_wvalid && wready_r;
    assign b_hs_s  = bvalid_r && s_bready;
    assign ar_hs_s = s_arvalid && arready_r;
    assign r_hs_s  = rvalid_r && s_rready;

    // Write and read FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r <= W_IDLE;
            rd_state_r <= R_IDLE;
        end else begin
            wr_state_r <= wr_next_s;
            rd_state_r <= rd_next_s;
        end
    end

    // Write FSM next state; a backdoor write in the commit cycle pushes the AXI commit back a cycle.
    always_comb begin
        wr_next_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) wr_next_s = W_COMMIT;
                else if (aw_hs_s)      wr_next_s = W_HAVE_A;
                else if (w_hs_s)       wr_next_s = W_HAVE_D;
                else                   wr_next_s = W_IDLE;
            end
            W_HAVE_A: wr_next_s = w_hs_s  ? W_COMMIT : W_HAVE_A;
            W_HAVE_D: wr_next_s = aw_hs_s ? W_COMMIT : W_HAVE_D;
            W_COMMIT: wr_next_s = bd_we   ? W_COMMIT : W_RESP;
            W_RESP:   wr_next_s = s_bready ? W_IDLE  : W_RESP;
            default:  wr_next_s = W_IDLE;
        endcase
    end

    // Read FSM next state.
    always_comb begin
        rd_next_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) rd_next_s = (RD_LATENCY == 1) ? R_VALID : R_WAIT;
                else         rd_next_s = R_IDLE;
            end
            R_WAIT:  rd_next_s = (lat_cnt_r == LAST_WAIT) ? R_VALID : R_WAIT;
            R_VALID: rd_next_s = s_rready ? R_IDLE : R_VALID;
            default: rd_next_s = R_IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they can be registered without lag.
    always_comb begin
        awready_s = (wr_next_s == W_IDLE) || (wr_next_s == W_HAVE_D);
        wready_s  = (wr_next_s == W_IDLE) || (wr_next_s == W_HAVE_A);
        bvalid_s  = (wr_next_s == W_RESP);
        bresp_s   = (bvalid_s && aw_oor_r) ? 2'b11 : 2'b00;
        arready_s = (rd_next_s == R_IDLE);
        rvalid_s  = (rd_next_s == R_VALID);
    end

    // Registered handshake/response outputs and completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            bvalid_r   <= 1'b0;
            bresp_r    <= 2'b00;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            wr_count_r <= 32'd0;
            rd_count_r <= 32'd0;
        end else begin
            awready_r  <= awready_s;
            wready_r   <= wready_s;
            bvalid_r   <= bvalid_s;
            bresp_r    <= bresp_s;
            arready_r  <= arready_s;
            rvalid_r   <= rvalid_s;
            wr_count_r <= b_hs_s ? wr_count_r + 32'd1 : wr_count_r;
            rd_count_r <= r_hs_s ? rd_count_r + 32'd1 : rd_count_r;
        end
    end

    // Capture the write address and data beats as they are accepted.
    always_ff @(posedge clk) begin
        if (aw_hs_s) begin
            aw_idx_r <= word_idx(s_awaddr);
            aw_oor_r <= addr_oor(s_awaddr);
        end
        if (w_hs_s) begin
            wdata_r <= s_wdata;
            wstrb_r <= s_wstrb;
        end
    end

    // Memory array: backdoor wins the single write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            if (!addr_oor(bd_addr)) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (bd_wstrb[b]) mem_r[word_idx(bd_addr)][8*b +: 8] <= bd_wdata[8*b +: 8];
                end
            end
        end else if (!rst && (wr_state_r == W_COMMIT) && !aw_oor_r) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb_r[b]) mem_r[aw_idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
            end
        end
    end

    // Read word sampled at the AR handshake, so only earlier commits are visible.
    always_comb begin
        rd_oor_s = addr_oor(s_araddr);
        if (rd_oor_s) rd_word_s = {DATA_WIDTH{1'b0}};
        else          rd_word_s = mem_r[word_idx(s_araddr)];
    end

    // Read latency counter, snapshot buffer and the held R-channel payload.
    always_ff @(posedge clk) begin
        if (ar_hs_s) begin
            rd_buf_r <= rd_word_s;
            rd_oor_r <= rd_oor_s;
        end
        if (rst) begin
            lat_cnt_r <= 4'd1;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            rresp_r   <= 2'b00;
        end else begin
            if (rd_state_r == R_WAIT) lat_cnt_r <= lat_cnt_r + 4'd1;
            else                      lat_cnt_r <= 4'd1;
            if (rvalid_s && !rvalid_r) begin
                rdata_r <= (rd_state_r == R_IDLE) ? rd_word_s : rd_buf_r;
                rresp_r <= ((rd_state_r == R_IDLE) ? rd_oor_s : rd_oor_r) ? 2'b11 : 2'b00;
            end
        end
    end

    assign s_awready = awready_r;
    assign s_wready  = wready_r;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_arready = arready_r;
    assign s_rvalid  = rvalid_r;
    assign s_rdata   = rdata_r;
    assign s_rresp   = rresp_r;
    assign wr_count  = wr_count_r;
    assign rd_count  = rd_count_r;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench for axi_lite_slave_mem (RD_LATENCY=3) against a word-array reference model.
module tb_axi_lite_slave_mem;

    localparam int          DEPTH = 1024;
    localparam int          RDL   = 3;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef AXI_MEM_RANGE_CHECK_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_awaddr = 32'd0, s_wdata = 32'd0, s_araddr = 32'd0;
    logic [3:0]  s_wstrb = 4'd0;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, wr_count, rd_count;
    logic        bd_we = 1'b0;
    logic [31:0] bd_addr = 32'd0, bd_wdata = 32'd0;
    logic [3:0]  bd_wstrb = 4'd0;

    int errors = 0;
    int checks = 0;
    int exp_wr = 0;
    int exp_rd = 0;
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    axi_lite_slave_mem #(.RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_wstrb(bd_wstrb),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    function automatic bit model_oor(input logic [31:0] a);
        return RC_EN && ((a < BASE) || ((a - BASE) >= 32'(DEPTH * 4)));
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'(((a - BASE) / 32'd4) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_oor(a) ? 32'd0 : model_mem[model_idx(a)];
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return model_oor(a) ? 2'b11 : 2'b00;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!model_oor(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model_mem[model_idx(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d; bd_wstrb = s;
        tick();
        bd_we = 1'b0;
        model_write(a, d, s);
    endtask

    // AW and W presented together; blat counts cycles from the last accepted beat to bvalid.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int blat);
        int  guard;
        bit  aw_f, w_f;
        s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wstrb = s; s_wvalid = 1'b1; s_bready = 1'b0;
        guard = 0;
        while ((s_awvalid || s_wvalid) && guard < 20) begin
            aw_f = s_awvalid && s_awready;
            w_f  = s_wvalid && s_wready;
            tick();
            guard++;
            if (aw_f) s_awvalid = 1'b0;
            if (w_f)  s_wvalid = 1'b0;
        end
        blat = 1;
        while (!s_bvalid && blat < 20) begin
            tick();
            blat++;
        end
        checks++;
        if (s_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, s_bvalid);
            s_awvalid = 1'b0; s_wvalid = 1'b0; resp = 2'bxx;
        end else begin
            resp = s_bresp;
            s_bready = 1'b1;
            tick();
            s_bready = 1'b0;
            exp_wr++;
            model_write(a, d, s);
        end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int guard;
        s_araddr = a; s_arvalid = 1'b1; guard = 0;
        while (!s_arready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        s_arvalid = 1'b0;
        lat = 1;
        while (!s_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (s_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, s_rvalid);
            data = 32'hxxxx_xxxx; resp = 2'bxx;
        end else begin
            data = s_rdata; resp = s_rresp;
            s_rready = 1'b1;
            tick();
            s_rready = 1'b0;
            exp_rd++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp} !== 9'b111_0_0_00_00) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=111000000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp});
        end
        checks++;
        if ({s_rdata, wr_count, rd_count} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data rdata=%h wr_count=%0d rd_count=%0d required 0", s_rdata, wr_count, rd_count);
        end
        for (int i = 0; i < DEPTH; i++) bd_write(32'(i * 4), $urandom, 4'hF);
        bd_write(32'h0000_0000, 32'h1000_0113, 4'hF);
        bd_write(32'h0000_0080, 32'hF81F_F06F, 4'hF);
    endtask

    task automatic test_preload();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        rst = 1'b0;
        tick();
        axi_read(32'h80, d, r, lat);
        checks++;
        if (lat !== RDL) begin errors++; $display("FAIL preload_latency got=%0d required=%0d", lat, RDL); end
        checks++;
        if (d !== 32'hF81F_F06F || r !== 2'b00) begin
            errors++; $display("FAIL preload_0x80 rdata=%h rresp=%b required F81FF06F/00", d, r);
        end
        checks++;
        if (rd_count !== 32'd1) begin errors++; $display("FAIL preload_rd_count got=%0d required=1", rd_count); end
        axi_read(32'h0, d, r, lat);
        checks++;
        if (d !== 32'h1000_0113) begin errors++; $display("FAIL preload_0x0 rdata=%h required=10000113", d); end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        int          blat;
        bd_write(32'h10, 32'h1122_3344, 4'hF);
        axi_write(32'h10, 32'hAABB_CCDD, 4'b0101, r, blat);
        checks++;
        if (r !== 2'b00 || blat !== 2) begin
            errors++; $display("FAIL strobe_bresp bresp=%b blat=%0d required 00/2", r, blat);
        end
        checks++;
        if (wr_count !== 32'd1) begin errors++; $display("FAIL strobe_wr_count got=%0d required=1", wr_count); end
        axi_read(32'h10, d, r, lat);
        checks++;
        if (d !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_data got=%h required=11BB33DD", d); end
    endtask

    task automatic test_channel_order();
        logic [31:0] d, q;
        logic [1:0]  r;
        int          n, lat;
        bit          ok;
        d = $urandom;
        s_wdata = d; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
        tick();
        s_wvalid = 1'b0;
        checks++;
        if (s_wready !== 1'b0 || s_awready !== 1'b1) begin
            errors++; $display("FAIL order_w_only wready=%b awready=%b required 0/1", s_wready, s_awready);
        end
        repeat (3) tick();
        s_awaddr = 32'h40; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        n = 1;
        while (!s_bvalid && n < 20) begin tick(); n++; end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL order_b_latency got=%0d required=2", n); end
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (s_bvalid !== 1'b1 || s_awready !== 1'b0) ok = 1'b0;
            tick();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL order_b_hold bvalid=%b awready=%b required 1/0", s_bvalid, s_awready); end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        exp_wr++;
        model_write(32'h40, d, 4'hF);
        checks++;
        if (s_awready !== 1'b1 || wr_count !== 32'(exp_wr)) begin
            errors++; $display("FAIL order_after_b awready=%b wr_count=%0d required 1/%0d", s_awready, wr_count, exp_wr);
        end
        axi_read(32'h40, q, r, lat);
        checks++;
        if (q !== d) begin errors++; $display("FAIL order_data got=%h required=%h", q, d); end
    endtask

    task automatic test_collision();
        logic [31:0] d1, d2, q, first;
        logic [1:0]  r;
        int          n, lat;
        bit          ok;
        d1 = $urandom; d2 = $urandom;
        s_awaddr = 32'h24; s_awvalid = 1'b1; s_wdata = d1; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        bd_write(32'h20, d2, 4'hF);
        n = 2;
        while (!s_bvalid && n < 20) begin tick(); n++; end
        checks++;
        if (n !== 3 || s_bresp !== 2'b00) begin
            errors++; $display("FAIL collision_b_latency got=%0d bresp=%b required 3/00", n, s_bresp);
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        exp_wr++;
        model_write(32'h24, d1, 4'hF);
        axi_read(32'h20, q, r, lat);
        checks++;
        if (q !== d2) begin errors++; $display("FAIL collision_bd_word got=%h required=%h", q, d2); end
        s_araddr = 32'h24; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        n = 1;
        while (!s_rvalid && n < 20) begin tick(); n++; end
        first = s_rdata;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_rvalid !== 1'b1 || s_rdata !== first) ok = 1'b0;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL collision_r_hold rvalid=%b rdata=%h required 1/%h", s_rvalid, s_rdata, first); end
        checks++;
        if (first !== d1 || n !== RDL) begin
            errors++; $display("FAIL collision_axi_word got=%h lat=%0d required=%h/%0d", first, n, d1, RDL);
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        exp_rd++;
    endtask

    task automatic test_range();
        logic [31:0] d, q;
        logic [1:0]  r;
        int          blat, lat;
        d = $urandom;
        axi_write(32'h1000, d, 4'hF, r, blat);
        checks++;
        if (r !== model_resp(32'h1000) || blat !== 2) begin
            errors++; $display("FAIL range_bresp got=%b blat=%0d required=%b/2", r, blat, model_resp(32'h1000));
        end
        bd_write(32'h2004, $urandom, 4'hF);
        axi_read(32'h0, q, r, lat);
        checks++;
        if (q !== model_mem[0]) begin errors++; $display("FAIL range_word0 got=%h required=%h", q, model_mem[0]); end
        axi_read(32'h1000, q, r, lat);
        checks++;
        if (q !== model_read(32'h1000) || r !== model_resp(32'h1000)) begin
            errors++; $display("FAIL range_read got=%h/%b required=%h/%b", q, r, model_read(32'h1000), model_resp(32'h1000));
        end
        axi_read(32'h4, q, r, lat);
        checks++;
        if (q !== model_mem[1]) begin errors++; $display("FAIL range_bd_word1 got=%h required=%h", q, model_mem[1]); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] q;
        logic [1:0]  r;
        int          lat;
        s_araddr = 32'h80; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b1 || rd_count !== 32'd0 || wr_count !== 32'd0) begin
            errors++; $display("FAIL midreset_state rvalid=%b arready=%b rd_count=%0d wr_count=%0d required 0/1/0/0",
                               s_rvalid, s_arready, rd_count, wr_count);
        end
        repeat (RDL + 2) tick();
        checks++;
        if (s_rvalid !== 1'b0) begin errors++; $display("FAIL midreset_stray_r rvalid=%b required 0", s_rvalid); end
        exp_rd = 0; exp_wr = 0;
        axi_read(32'h80, q, r, lat);
        checks++;
        if (q !== 32'hF81F_F06F || rd_count !== 32'd1) begin
            errors++; $display("FAIL midreset_mem got=%h rd_count=%0d required F81FF06F/1", q, rd_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, q;
        logic [3:0]  s;
        logic [1:0]  r;
        int          lat, blat, op;
        for (int i = 0; i < 60; i++) begin
            a  = 32'($urandom_range(0, 32'h17FF));
            d  = $urandom;
            s  = 4'($urandom_range(1, 15));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                axi_write(a, d, s, r, blat);
                checks++;
                if (r !== model_resp(a) || blat !== 2) begin
                    errors++; $display("FAIL rand_write addr=%h bresp=%b blat=%0d required %b/2", a, r, blat, model_resp(a));
                end
            end else if (op == 1) begin
                axi_read(a, q, r, lat);
                checks++;
                if (q !== model_read(a) || r !== model_resp(a) || lat !== RDL) begin
                    errors++; $display("FAIL rand_read addr=%h got=%h/%b/%0d required %h/%b/%0d",
                                       a, q, r, lat, model_read(a), model_resp(a), RDL);
                end
            end else begin
                bd_write(a, d, s);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        checks++;
        if (wr_count !== 32'(exp_wr) || rd_count !== 32'(exp_rd)) begin
            errors++; $display("FAIL rand_counts wr=%0d rd=%0d required %0d/%0d", wr_count, rd_count, exp_wr, exp_rd);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_partial_strobe();
        test_channel_order();
        test_collision();
        test_range();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish required completion");
        $fatal(1, "watchdog");
    end

endmodule
